// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit
// ----------------------------------------------------------------------------
// Instruction-fetch stage that drives the IF/ID pipeline register (PC_o and
// Inst_o). It owns the fetch PC and keeps at most one request outstanding on
// a req/gnt/rvalid instruction-memory port. It honours a hazard stall and a
// branch flush. Whenever no fetched word is ready, it presents a NOP bubble
// (Inst_o = 0, fetch_wait_o = 1).
//
// Handshake (instruction memory):
//   imem_req_o is raised in REQ. imem_addr_o is held stable, and the request
//   is never withdrawn, until imem_gnt_i is seen high at a rising edge.
//   Exactly one response (imem_rvalid_i with imem_rdata_i) follows one or
//   more cycles later. It is accepted only in WAIT. A gnt seen outside REQ is
//   ignored, and an rvalid seen outside WAIT is ignored.
//
// Parameters:
//   RESET_PC        fetch address after reset (bits [1:0] forced to zero)
//
// Ports:
//   clk_i           clock, all state updates on the rising edge
//   rst_i           synchronous reset, active-high
//   stall_i         hazard stall: hold the presented instruction, no PC advance
//   flush_i         redirect to target_i; has priority over stall_i
//   target_i        redirect PC, sampled while flush_i = 1
//   imem_req_o      fetch request
//   imem_addr_o     fetch address, word aligned
//   imem_gnt_i      request accepted this cycle
//   imem_rvalid_i   read data valid
//   imem_rdata_i    instruction word
//   PC_o            PC of the presented slot (the fetch PC register)
//   Inst_o          presented instruction, 0 while fetch_wait_o = 1
//   fetch_wait_o    1 = no valid instruction this cycle
//   dbg_state_o     current FSM state (IDLE=0, REQ=1, WAIT=2, VALID=3)
//
// Optional feature (macro FETCH_PERF_EN):
//   perf_fetch_o    instructions consumed (VALID & !stall_i & !flush_i)
//   perf_wait_o     cycles spent in REQ or WAIT
//   Both counters reset to 0 and wrap at 2^32. Without the macro, these
//   ports and counters do not exist.
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] PC_o,
    output logic [31:0] Inst_o,
    output logic        fetch_wait_o,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_wait_o,
`endif
    output logic [1:0]  dbg_state_o
);

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_VALID = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_tgt;    // redirect target, parked until the response returns
    logic        r_kill;   // 1 = the in-flight response must be discarded
    logic [31:0] r_inst;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_tgt_nxt;
    logic        w_kill_nxt;
    logic [31:0] w_inst_nxt;
    logic [31:0] w_target_aligned;

    assign w_target_aligned = target_i & 32'hFFFF_FFFC;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC_ALIGNED;
            r_tgt   <= 32'h0;
            r_kill  <= 1'b0;
            r_inst  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_tgt   <= w_tgt_nxt;
            r_kill  <= w_kill_nxt;
            r_inst  <= w_inst_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_tgt_nxt   = r_tgt;
        w_kill_nxt  = r_kill;
        w_inst_nxt  = r_inst;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_REQ;
                if (flush_i) begin
                    w_pc_nxt   = w_target_aligned;
                    w_kill_nxt = 1'b0;
                end
            end
            ST_REQ: begin
                // The address must stay put until gnt, so a flush here only
                // marks the eventual response as dead and parks the target.
                if (flush_i) begin
                    w_tgt_nxt  = w_target_aligned;
                    w_kill_nxt = 1'b1;
                end
                if (imem_gnt_i) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    if (flush_i) begin
                        // A flush arriving with the data supersedes any parked target.
                        w_pc_nxt    = w_target_aligned;
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = ST_REQ;
                    end else if (r_kill) begin
                        w_pc_nxt    = r_tgt;
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_inst_nxt  = imem_rdata_i;
                        w_state_nxt = ST_VALID;
                    end
                end else if (flush_i) begin
                    w_tgt_nxt  = w_target_aligned;
                    w_kill_nxt = 1'b1;
                end
            end
            ST_VALID: begin
                if (flush_i) begin
                    w_pc_nxt    = w_target_aligned;
                    w_kill_nxt  = 1'b0;
                    w_state_nxt = ST_REQ;
                end else if (!stall_i) begin
                    // Consumed by IF/ID at this edge; wraps modulo 2^32.
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign imem_req_o   = (r_state == ST_REQ);
    assign imem_addr_o  = r_pc;
    assign PC_o         = r_pc;
    assign Inst_o       = (r_state == ST_VALID) ? r_inst : 32'h0;
    assign fetch_wait_o = (r_state != ST_VALID);
    assign dbg_state_o  = r_state;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_wait;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_fetch <= 32'h0;
            r_perf_wait  <= 32'h0;
        end else begin
            if ((r_state == ST_VALID) && !stall_i && !flush_i) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if ((r_state == ST_REQ) || (r_state == ST_WAIT)) begin
                r_perf_wait <= r_perf_wait + 32'd1;
            end
        end
    end

    assign perf_fetch_o = r_perf_fetch;
    assign perf_wait_o  = r_perf_wait;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// tb_if_fetch_unit
// ----------------------------------------------------------------------------
// Self-checking bench for if_fetch_unit (RESET_PC = 0x100). It has three
// parts:
//   1. A per-cycle vector table of {inputs, expected outputs}: basic fetch,
//      grant back-pressure, stall hold, the flush cases, PC wrap and reset
//      mid-transaction.
//   2. A hand-written sequence for a flush in the first cycle after reset.
//   3. Randomised traffic checked against a transaction-level reference model.
// ============================================================================
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst, stall, flush, gnt, rvalid;
    logic [31:0] target, rdata;
    logic        req, fwait;
    logic [31:0] addr, pc, inst;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .flush_i       (flush),
        .target_i      (target),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_gnt_i    (gnt),
        .imem_rvalid_i (rvalid),
        .imem_rdata_i  (rdata),
        .PC_o          (pc),
        .Inst_o        (inst),
        .fetch_wait_o  (fwait),
        .dbg_state_o   (dbg_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic [31:0] t,
                         input logic g, input logic v, input logic [31:0] d);
        rst = r; stall = s; flush = f; target = t; gnt = g; rvalid = v; rdata = d;
    endtask

    // ---------------- vector table ----------------
    // Each row: the outputs expected in this cycle, then the inputs applied
    // during it (they take effect at the following rising edge).
    typedef struct {
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_wt;
        logic        rst, st, fl;
        logic [31:0] tgt;
        logic        gnt, rv;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic er, input logic [31:0] ea, input logic [31:0] ep,
                       input logic [31:0] ei, input logic ew,
                       input logic r, input logic s, input logic f, input logic [31:0] t,
                       input logic g, input logic v, input logic [31:0] d);
        vec_t x;
        x.e_req = er; x.e_addr = ea; x.e_pc = ep; x.e_inst = ei; x.e_wt = ew;
        x.rst = r; x.st = s; x.fl = f; x.tgt = t; x.gnt = g; x.rv = v; x.rdata = d;
        vecs.push_back(x);
    endtask

    // ---------------- reference model ----------------
    // Transaction view: after reset there is one setup cycle; then the unit
    // asks for m_fetch_pc, awaits the reply, and shows the word until it is
    // consumed. A flush during the ask/await phase dooms the reply and parks
    // the redirect.
    logic        m_starting, m_asking, m_awaiting, m_showing, m_doomed;
    logic [31:0] m_fetch_pc, m_redirect, m_word;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic model_step(input logic r, input logic s, input logic f, input logic [31:0] t,
                              input logic g, input logic v, input logic [31:0] d);
        logic [31:0] ta;
        ta = t & 32'hFFFF_FFFC;
        if (r) begin
            m_starting = 1'b1; m_asking = 1'b0; m_awaiting = 1'b0; m_showing = 1'b0;
            m_doomed = 1'b0; m_fetch_pc = RESET_PC; m_word = 32'h0; m_redirect = 32'h0;
        end else if (m_starting) begin
            m_starting = 1'b0;
            m_asking = 1'b1;
            if (f) begin
                m_fetch_pc = ta;
                m_doomed = 1'b0;
            end
        end else if (m_asking) begin
            if (f) begin
                m_redirect = ta;
                m_doomed = 1'b1;
            end
            if (g) begin
                m_asking = 1'b0;
                m_awaiting = 1'b1;
            end
        end else if (m_awaiting) begin
            if (v) begin
                m_awaiting = 1'b0;
                if (f || m_doomed) begin
                    m_fetch_pc = f ? ta : m_redirect;
                    m_doomed = 1'b0;
                    m_asking = 1'b1;
                end else begin
                    m_word = d;
                    m_showing = 1'b1;
                end
            end else if (f) begin
                m_redirect = ta;
                m_doomed = 1'b1;
            end
        end else if (m_showing) begin
            if (f) begin
                m_fetch_pc = ta;
                m_showing = 1'b0;
                m_doomed = 1'b0;
                m_asking = 1'b1;
            end else if (!s) begin
                m_fetch_pc = m_fetch_pc + 32'd4;
                m_showing = 1'b0;
                m_asking = 1'b1;
            end
        end
    endtask

    initial begin
        logic        r_r, r_s, r_f, r_g, r_v;
        logic [31:0] r_t, r_d;
        bit          seen;

        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);

        // e_req e_addr e_pc e_inst e_wt | rst st fl tgt gnt rv rdata
        add(0, 32'h100, 32'h100, 32'h0, 1,  0,0,0, 32'h0, 1,0, 32'h0);
        add(1, 32'h100, 32'h100, 32'h0, 1,  0,0,0, 32'h0, 1,0, 32'h0);
        add(0, 32'h100, 32'h100, 32'h0, 1,  0,0,0, 32'h0, 1,1, 32'h100);
        add(0, 32'h100, 32'h100, 32'h100, 0, 0,0,0, 32'h0, 1,0, 32'h0);
        for (int i = 0; i < 3; i++)
            add(1, 32'h104, 32'h104, 32'h0, 1, 0,0,0, 32'h0, 0,0, 32'h0);
        add(1, 32'h104, 32'h104, 32'h0, 1,  0,0,0, 32'h0, 1,0, 32'h0);
        add(0, 32'h104, 32'h104, 32'h0, 1,  0,0,0, 32'h0, 0,1, 32'h13);
        add(0, 32'h104, 32'h104, 32'h13, 0, 0,1,0, 32'h0, 1,0, 32'h0);
        add(0, 32'h104, 32'h104, 32'h13, 0, 0,1,0, 32'h0, 1,1, 32'hBAD0_BAD0);
        add(0, 32'h104, 32'h104, 32'h13, 0, 0,1,0, 32'h0, 0,0, 32'h0);
        add(0, 32'h104, 32'h104, 32'h13, 0, 0,1,0, 32'h0, 0,0, 32'h0);
        add(0, 32'h104, 32'h104, 32'h13, 0, 0,0,0, 32'h0, 0,0, 32'h0);
        add(1, 32'h108, 32'h108, 32'h0, 1,  0,0,0, 32'h0, 1,0, 32'h0);
        add(0, 32'h108, 32'h108, 32'h0, 1,  0,0,1, 32'h200, 0,0, 32'h0);
        add(0, 32'h108, 32'h108, 32'h0, 1,  0,0,0, 32'h0, 0,0, 32'h0);
        add(0, 32'h108, 32'h108, 32'h0, 1,  0,0,0, 32'h0, 0,1, 32'hBADB_AD01);
        add(1, 32'h200, 32'h200, 32'h0, 1,  0,0,0, 32'h0, 1,0, 32'h0);
        add(0, 32'h200, 32'h200, 32'h0, 1,  0,0,0, 32'h0, 0,1, 32'h200);
        add(0, 32'h200, 32'h200, 32'h200, 0, 0,1,1, 32'h203, 0,0, 32'h0);
        add(1, 32'h200, 32'h200, 32'h0, 1,  0,0,0, 32'h0, 1,0, 32'h0);
        add(0, 32'h200, 32'h200, 32'h0, 1,  0,0,0, 32'h0, 0,1, 32'h1111_1111);
        add(0, 32'h200, 32'h200, 32'h1111_1111, 0, 0,0,1, 32'hFFFF_FFFE, 0,0, 32'h0);
        add(1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1, 0,0,0, 32'h0, 1,0, 32'h0);
        add(0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1, 0,0,0, 32'h0, 0,1, 32'h2222_2222);
        add(0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h2222_2222, 0, 0,0,0, 32'h0, 0,0, 32'h0);
        add(1, 32'h0, 32'h0, 32'h0, 1,      0,0,0, 32'h0, 1,0, 32'h0);
        add(0, 32'h0, 32'h0, 32'h0, 1,      1,0,0, 32'h0, 0,0, 32'h0);
        add(0, 32'h100, 32'h100, 32'h0, 1,  0,0,0, 32'h0, 0,1, 32'hBAD0_0001);
        add(1, 32'h100, 32'h100, 32'h0, 1,  0,0,0, 32'h0, 0,0, 32'h0);
        add(1, 32'h100, 32'h100, 32'h0, 1,  0,0,1, 32'h300, 0,0, 32'h0);
        add(1, 32'h100, 32'h100, 32'h0, 1,  0,0,1, 32'h340, 1,0, 32'h0);
        add(0, 32'h100, 32'h100, 32'h0, 1,  0,0,0, 32'h0, 0,1, 32'hBAD2);
        add(1, 32'h340, 32'h340, 32'h0, 1,  0,0,0, 32'h0, 1,0, 32'h0);
        add(0, 32'h340, 32'h340, 32'h0, 1,  0,0,1, 32'h400, 0,1, 32'hBAD3);
        add(1, 32'h400, 32'h400, 32'h0, 1,  0,0,0, 32'h0, 1,0, 32'h0);
        add(0, 32'h400, 32'h400, 32'h0, 1,  0,0,0, 32'h0, 0,1, 32'h400);
        add(0, 32'h400, 32'h400, 32'h400, 0, 0,0,0, 32'h0, 0,0, 32'h0);
        add(1, 32'h404, 32'h404, 32'h0, 1,  0,0,0, 32'h0, 0,0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (i == 0) chk("reset dbg_state", {30'h0, dbg_state}, 32'h0);
            chk($sformatf("vec%0d req", i),   {31'h0, req},   {31'h0, vecs[i].e_req});
            chk($sformatf("vec%0d addr", i),  addr,           vecs[i].e_addr);
            chk($sformatf("vec%0d pc", i),    pc,             vecs[i].e_pc);
            chk($sformatf("vec%0d inst", i),  inst,           vecs[i].e_inst);
            chk($sformatf("vec%0d wait", i),  {31'h0, fwait}, {31'h0, vecs[i].e_wt});
            drive(vecs[i].rst, vecs[i].st, vecs[i].fl, vecs[i].tgt,
                  vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
        end

        // ---------------- flush in the setup cycle after reset ----------------
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk); drive(1'b0, 1'b0, 1'b1, 32'h5A7, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("idle flush req", {31'h0, req}, 32'h1);
        chk("idle flush addr", addr, 32'h5A4);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_0013);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            if (!fwait) seen = 1'b1;
        end
        chk("idle flush word arrives", {31'h0, seen}, 32'h1);
        chk("idle flush inst", inst, 32'hCAFE_0013);
        chk("idle flush pc", pc, 32'h5A4);

        // ---------------- randomised traffic vs reference model ----------------
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        model_step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            chk("rand req",  {31'h0, req},   {31'h0, m_asking});
            chk("rand addr", addr,           m_fetch_pc);
            chk("rand pc",   pc,             m_fetch_pc);
            chk("rand inst", inst,           m_showing ? m_word : 32'h0);
            chk("rand wait", {31'h0, fwait}, {31'h0, !m_showing});
            r_r = ($urandom_range(0, 299) == 0);
            r_s = ($urandom_range(0, 2) == 0);
            r_f = ($urandom_range(0, 9) == 0);
            r_t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            r_g = ($urandom_range(0, 1) == 1);
            if (m_awaiting) begin
                r_v = ($urandom_range(0, 2) != 0);
                r_d = mem_word(m_fetch_pc);
            end else begin
                r_v = ($urandom_range(0, 7) == 0);
                r_d = 32'hDEAD_0000 | 32'($urandom_range(0, 255));
            end
            drive(r_r, r_s, r_f, r_t, r_g, r_v, r_d);
            model_step(r_r, r_s, r_f, r_t, r_g, r_v, r_d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
